// File: rtl/register_file_pkg.sv
// Shared types and constants for the multi-port register file and its clear engine.
package register_file_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clear_state_t;

  localparam int DEFAULT_DATA_WIDTH    = 64;
  localparam int DEFAULT_LOG2_NUM_REGS = 5;
  localparam int DEFAULT_NUM_REGS      = 32;

  // Low bit position of slice idx inside a packed bus of width-bit slices.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/register_file_clear_fsm.sv
// Bulk-clear sequencer: walks a counter over every register, one per cycle,
// and reports busy/done. Also tells the array when normal writes are allowed.
module register_file_clear_fsm
  import register_file_pkg::*;
#(
  parameter int LOG2_NUM_REGS = DEFAULT_LOG2_NUM_REGS,
  parameter int NUM_REGS      = DEFAULT_NUM_REGS
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear_start,
  output logic                     clear_busy,
  output logic                     clear_done,
  output logic                     clear_we,
  output logic [LOG2_NUM_REGS-1:0] clear_addr,
  output logic                     write_allow
);

  localparam logic [LOG2_NUM_REGS-1:0] LAST_ADDR = LOG2_NUM_REGS'(NUM_REGS - 1);

  clear_state_t               state;
  logic [LOG2_NUM_REGS-1:0]   counter;

  // State, counter and the registered busy/done flags; the counter stops at
  // the last register so it never wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      counter    <= '0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          clear_done <= 1'b0;
          if (clear_start) begin
            state      <= CLEAR;
            counter    <= '0;
            clear_busy <= 1'b1;
          end
        end
        CLEAR: begin
          if (counter == LAST_ADDR) begin
            state      <= DONE;
            clear_busy <= 1'b0;
            clear_done <= 1'b1;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          clear_done <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          clear_busy <= 1'b0;
          clear_done <= 1'b0;
        end
      endcase
    end
  end

  assign clear_we    = (state == CLEAR);
  assign clear_addr  = counter;
  assign write_allow = (state == IDLE);

endmodule

// File: rtl/register_file_mp.sv
// Parametrised multi-port register file with registered reads, write-to-read
// bypass, optional hardwired-zero register and a sequential bulk clear.
module register_file_mp
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int LOG2_NUM_REGS = DEFAULT_LOG2_NUM_REGS,
  parameter int NUM_REGS      = DEFAULT_NUM_REGS,
  parameter int NUM_RD        = 2,
  parameter int NUM_WR        = 1,
  parameter int ZERO_REG_EN   = 1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_RD-1:0]               read_en,
  input  logic [NUM_RD*LOG2_NUM_REGS-1:0] raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0]    rdata,
  input  logic [NUM_WR-1:0]               write_en,
  input  logic [NUM_WR*LOG2_NUM_REGS-1:0] waddr,
  input  logic [NUM_WR*DATA_WIDTH-1:0]    wdata,
  input  logic                            clear_start,
  output logic                            clear_busy,
  output logic                            clear_done
);

  logic [DATA_WIDTH-1:0]    regs    [NUM_REGS];
  logic [LOG2_NUM_REGS-1:0] wr_addr [NUM_WR];
  logic [DATA_WIDTH-1:0]    wr_data [NUM_WR];
  logic [NUM_WR-1:0]        wr_ok;
  logic [LOG2_NUM_REGS-1:0] rd_addr [NUM_RD];
  logic [DATA_WIDTH-1:0]    rd_next [NUM_RD];

  logic                     clear_we;
  logic [LOG2_NUM_REGS-1:0] clear_addr;
  logic                     write_allow;

  register_file_clear_fsm #(
    .LOG2_NUM_REGS(LOG2_NUM_REGS),
    .NUM_REGS     (NUM_REGS)
  ) u_clear_fsm (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear_start(clear_start),
    .clear_busy (clear_busy),
    .clear_done (clear_done),
    .clear_we   (clear_we),
    .clear_addr (clear_addr),
    .write_allow(write_allow)
  );

  // Unpack write ports and decide which writes are accepted this cycle:
  // only while idle, in range, and never to a hardwired-zero register 0.
  for (genvar w = 0; w < NUM_WR; w++) begin : g_wr
    assign wr_addr[w] = waddr[slice_lo(w, LOG2_NUM_REGS) +: LOG2_NUM_REGS];
    assign wr_data[w] = wdata[slice_lo(w, DATA_WIDTH) +: DATA_WIDTH];
    assign wr_ok[w]   = write_en[w] && write_allow &&
                        (int'(wr_addr[w]) < NUM_REGS) &&
                        !((ZERO_REG_EN != 0) && (wr_addr[w] == '0));
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    assign rd_addr[i] = raddr[slice_lo(i, LOG2_NUM_REGS) +: LOG2_NUM_REGS];
  end

  // Register array update; later ports override earlier ones on an address
  // conflict, and the clear engine zeroes one register per cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (wr_ok[w] && (int'(wr_addr[w]) == r)) regs[r] <= wr_data[w];
        end
        if (clear_we && (int'(clear_addr) == r)) regs[r] <= '0;
      end
    end
  end

  // Next read value per port: array contents, overridden by same-edge writes
  // (highest port last), clear zeroing, and the zero/out-of-range rules.
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rd_next[i] = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
        if (int'(rd_addr[i]) == r) rd_next[i] = regs[r];
      end
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_ok[w] && (wr_addr[w] == rd_addr[i])) rd_next[i] = wr_data[w];
      end
      if (clear_we && (clear_addr == rd_addr[i])) rd_next[i] = '0;
      if ((ZERO_REG_EN != 0) && (rd_addr[i] == '0)) rd_next[i] = '0;
    end
  end

  // Registered read data; a disabled port keeps its last value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata <= '0;
    end else begin
      for (int i = 0; i < NUM_RD; i++) begin
        if (read_en[i]) rdata[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH] <= rd_next[i];
      end
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: a default 2R/1W 32x64 instance with a
// zero register, plus a 1R/2W 24-entry instance without one.
module tb_register_file_mp;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  // Instance A: defaults
  logic [1:0]   a_read_en = '0;
  logic [9:0]   a_raddr = '0;
  logic [127:0] a_rdata;
  logic [0:0]   a_write_en = '0;
  logic [4:0]   a_waddr = '0;
  logic [63:0]  a_wdata = '0;
  logic         a_clear_start = 1'b0;
  logic         a_clear_busy;
  logic         a_clear_done;

  // Instance B: two write ports, 24 registers, no zero register
  logic [0:0]   b_read_en = '0;
  logic [4:0]   b_raddr = '0;
  logic [63:0]  b_rdata;
  logic [1:0]   b_write_en = '0;
  logic [9:0]   b_waddr = '0;
  logic [127:0] b_wdata = '0;
  logic         b_clear_start = 1'b0;
  logic         b_clear_busy;
  logic         b_clear_done;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic        re0;
    logic [4:0]  ra0;
    logic        re1;
    logic [4:0]  ra1;
    logic [63:0] e0;
    logic [63:0] e1;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  register_file_mp dut_a (
    .clk        (clk),
    .reset_n    (reset_n),
    .read_en    (a_read_en),
    .raddr      (a_raddr),
    .rdata      (a_rdata),
    .write_en   (a_write_en),
    .waddr      (a_waddr),
    .wdata      (a_wdata),
    .clear_start(a_clear_start),
    .clear_busy (a_clear_busy),
    .clear_done (a_clear_done)
  );

  register_file_mp #(
    .DATA_WIDTH   (64),
    .LOG2_NUM_REGS(5),
    .NUM_REGS     (24),
    .NUM_RD       (1),
    .NUM_WR       (2),
    .ZERO_REG_EN  (0)
  ) dut_b (
    .clk        (clk),
    .reset_n    (reset_n),
    .read_en    (b_read_en),
    .raddr      (b_raddr),
    .rdata      (b_rdata),
    .write_en   (b_write_en),
    .waddr      (b_waddr),
    .wdata      (b_wdata),
    .clear_start(b_clear_start),
    .clear_busy (b_clear_busy),
    .clear_done (b_clear_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    a_write_en = v.we;
    a_waddr    = v.wa;
    a_wdata    = v.wd;
    a_read_en  = {v.re1, v.re0};
    a_raddr    = {v.ra1, v.ra0};
    tick();
    a_write_en = '0;
    a_read_en  = '0;
  endtask

  task automatic aWrite(input int r, input logic [63:0] d);
    a_write_en = 1'b1;
    a_waddr    = 5'(r);
    a_wdata    = d;
    tick();
    a_write_en = 1'b0;
  endtask

  task automatic aRead(input int r0, input int r1);
    a_read_en = 2'b11;
    a_raddr   = {5'(r1), 5'(r0)};
    tick();
    a_read_en = 2'b00;
  endtask

  task automatic bRead(input int r);
    b_read_en = 1'b1;
    b_raddr   = 5'(r);
    tick();
    b_read_en = 1'b0;
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    int done_at;

    vecs[0] = '{1'b1, 5'd5, 64'hDEADBEEF_CAFEF00D, 1'b1, 5'd5, 1'b0, 5'd0, 64'hDEADBEEF_CAFEF00D, 64'h0};
    vecs[1] = '{1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 1'b1, 5'd5, 64'hDEADBEEF_CAFEF00D, 64'hDEADBEEF_CAFEF00D};
    vecs[2] = '{1'b1, 5'd5, 64'h1234, 1'b1, 5'd5, 1'b1, 5'd5, 64'h1234, 64'h1234};
    vecs[3] = '{1'b1, 5'd0, 64'hFFFF, 1'b1, 5'd0, 1'b0, 5'd0, 64'h0, 64'h1234};
    vecs[4] = '{1'b0, 5'd0, 64'h0, 1'b1, 5'd0, 1'b1, 5'd5, 64'h0, 64'h1234};
    vecs[5] = '{1'b1, 5'd9, 64'hAAAA, 1'b1, 5'd9, 1'b1, 5'd31, 64'hAAAA, 64'h0};
    vecs[6] = '{1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 1'b1, 5'd9, 64'hAAAA, 64'hAAAA};

    // Reset state
    #23;
    checkOutput("reset_rdata0", a_rdata[63:0], 64'h0);
    checkOutput("reset_rdata1", a_rdata[127:64], 64'h0);
    checkOutput("reset_busy", 64'(a_clear_busy), 64'h0);
    checkOutput("reset_done", 64'(a_clear_done), 64'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();

    // Every register reads zero after reset
    for (int r = 0; r < 32; r++) begin
      aRead(r, 31 - r);
      checkOutput("post_reset_read0", a_rdata[63:0], 64'h0);
      checkOutput("post_reset_read1", a_rdata[127:64], 64'h0);
    end

    // Table: latency, hold, bypass, zero register
    for (int k = 0; k < 7; k++) begin
      applyStimulus(vecs[k]);
      checkOutput($sformatf("vec%0d_rdata0", k), a_rdata[63:0], vecs[k].e0);
      checkOutput($sformatf("vec%0d_rdata1", k), a_rdata[127:64], vecs[k].e1);
    end

    // Instance B: same-address conflict, highest port wins, with bypass
    b_write_en = 2'b11;
    b_waddr    = {5'd7, 5'd7};
    b_wdata    = {64'h22, 64'h11};
    b_read_en  = 1'b1;
    b_raddr    = 5'd7;
    tick();
    b_write_en = 2'b00;
    b_read_en  = 1'b0;
    checkOutput("b_conflict_bypass", b_rdata, 64'h22);
    bRead(7);
    checkOutput("b_conflict_stored", b_rdata, 64'h22);

    // Instance B: register 0 is ordinary storage
    b_write_en = 2'b01;
    b_waddr    = {5'd0, 5'd0};
    b_wdata    = {64'h0, 64'hFFFF};
    b_read_en  = 1'b1;
    b_raddr    = 5'd0;
    tick();
    b_write_en = 2'b00;
    b_read_en  = 1'b0;
    checkOutput("b_r0_bypass", b_rdata, 64'hFFFF);
    bRead(0);
    checkOutput("b_r0_stored", b_rdata, 64'hFFFF);

    // Instance B: last in-range register versus an out-of-range address
    b_write_en = 2'b11;
    b_waddr    = {5'd23, 5'd25};
    b_wdata    = {64'h33, 64'h55};
    tick();
    b_write_en = 2'b00;
    bRead(23);
    checkOutput("b_last_reg", b_rdata, 64'h33);
    b_write_en = 2'b01;
    b_waddr    = {5'd0, 5'd25};
    b_wdata    = {64'h0, 64'h66};
    b_read_en  = 1'b1;
    b_raddr    = 5'd25;
    tick();
    b_write_en = 2'b00;
    b_read_en  = 1'b0;
    checkOutput("b_oor_bypass", b_rdata, 64'h0);
    bRead(25);
    checkOutput("b_oor_read", b_rdata, 64'h0);

    // Bulk clear: fill with index+1
    for (int r = 0; r < 32; r++) aWrite(r, 64'(r + 1));
    aRead(0, 31);
    checkOutput("fill_r0", a_rdata[63:0], 64'h0);
    checkOutput("fill_r31", a_rdata[127:64], 64'd32);

    a_clear_start = 1'b1;
    tick();
    a_clear_start = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    for (int j = 0; j < 40; j++) begin
      if (a_clear_busy) busy_cnt++;
      if (a_clear_done) begin
        done_cnt++;
        done_at = j;
      end
      if (j == 4) begin
        checkOutput("clear_same_edge_zero", a_rdata[63:0], 64'h0);
        checkOutput("clear_read_uncleared", a_rdata[127:64], 64'd32);
      end
      if (j == 11) checkOutput("clear_write_dropped", a_rdata[127:64], 64'd32);
      a_read_en     = 2'b00;
      a_write_en    = 1'b0;
      a_clear_start = 1'b0;
      if (j == 3) begin
        a_read_en = 2'b11;
        a_raddr   = {5'd31, 5'd3};
      end
      if (j == 5) begin
        a_write_en    = 1'b1;
        a_waddr       = 5'd31;
        a_wdata       = 64'h77;
        a_clear_start = 1'b1;
      end
      if (j == 10) begin
        a_read_en = 2'b10;
        a_raddr   = {5'd31, 5'd0};
      end
      tick();
    end
    a_read_en     = 2'b00;
    a_write_en    = 1'b0;
    a_clear_start = 1'b0;
    checkOutput("clear_busy_cycles", 64'(busy_cnt), 64'd32);
    checkOutput("clear_done_pulses", 64'(done_cnt), 64'd1);
    checkOutput("clear_done_cycle", 64'(done_at), 64'd32);
    for (int r = 0; r < 32; r++) begin
      aRead(r, r);
      checkOutput("after_clear_read0", a_rdata[63:0], 64'h0);
      checkOutput("after_clear_read1", a_rdata[127:64], 64'h0);
    end

    // Reset in the middle of a clear
    aWrite(20, 64'd6);
    aWrite(31, 64'd7);
    aRead(20, 31);
    checkOutput("refill_r20", a_rdata[63:0], 64'd6);
    a_clear_start = 1'b1;
    tick();
    a_clear_start = 1'b0;
    for (int j = 0; j < 10; j++) tick();
    checkOutput("midclear_busy_before_reset", 64'(a_clear_busy), 64'h1);
    reset_n = 1'b0;
    #1;
    checkOutput("midclear_busy_at_reset", 64'(a_clear_busy), 64'h0);
    checkOutput("midclear_done_at_reset", 64'(a_clear_done), 64'h0);
    checkOutput("midclear_rdata_at_reset", a_rdata[127:64], 64'h0);
    tick();
    tick();
    reset_n = 1'b1;
    busy_cnt = 0;
    done_cnt = 0;
    for (int j = 0; j < 40; j++) begin
      tick();
      if (a_clear_busy) busy_cnt++;
      if (a_clear_done) done_cnt++;
    end
    checkOutput("after_reset_busy_cycles", 64'(busy_cnt), 64'd0);
    checkOutput("after_reset_done_pulses", 64'(done_cnt), 64'd0);
    for (int r = 0; r < 32; r++) begin
      aRead(r, 31 - r);
      checkOutput("after_reset_read0", a_rdata[63:0], 64'h0);
      checkOutput("after_reset_read1", a_rdata[127:64], 64'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
